regfile_mp: RTL

- Parametrised successor to the single-port MIPS register file: NUM_RD registered read ports, one write port, and a hardwired-zero register 0.
- Adds write-first bypass, synchronous reset of the storage array, and a per-register pending-write scoreboard.
- The scoreboard lets the decode stage detect load-use and multi-cycle-producer hazards.
- Sits between decode (read ports, reserve) and writeback (write port).

---
 rtl/mips_pkg.sv | 17 +
 rtl/regfile_rdport.sv | 44 ++++
 rtl/regfile_mp.sv | 73 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared register-file constants for the MIPS pipeline: default widths,
// the hardwired-zero index and well-known register names.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: zero check, write-first bypass and the
// registered busy flag taken from the post-update pending vector.
module regfile_rdport
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [NREG],
    input  logic [NREG-1:0]   pend_next,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic rd_is_zero;
    logic bypass_hit;

    assign rd_is_zero = (rd_addr == ADDR_W'(REG_ZERO));
    assign bypass_hit = we && (wr_addr == rd_addr) && !rd_is_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else begin
            if (rd_is_zero)
                rd_data <= '0;
            else if (bypass_hit)
                rd_data <= wr_data;
            else
                rd_data <= regs[rd_addr];
            // pend_next[0] is never set, so address 0 reads as not busy
            rd_busy <= pend_next[rd_addr];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, one write port,
// hardwired-zero r0 and a per-register pending-write scoreboard.
module regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr
);

    localparam int NREG = depth_of(ADDR_W);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pend_next;
    logic              wr_ok;
    logic              rsv_ok;

    assign wr_ok  = we && (wr_addr != ADDR_W'(REG_ZERO));
    assign rsv_ok = rsv_en && (rsv_addr != ADDR_W'(REG_ZERO));

    // Reserve is applied after the clear so a same-edge reserve wins.
    always_comb begin
        pend_next = pending;
        if (wr_ok)
            pend_next[wr_addr] = 1'b0;
        if (rsv_ok)
            pend_next[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            pending <= pend_next;
            if (wr_ok)
                regs[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rdport
        regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NREG   (NREG)
        ) u_rdport (
            .clock     (clock),
            .reset     (reset),
            .rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
            .regs      (regs),
            .pend_next (pend_next),
            .we        (we),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_data   (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy   (rd_busy[p])
        );
    end

endmodule
